// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder with a start/done handshake.
// Operands are added LSB-first, one bit per clock. A single full-adder cell
// is built from two half-adder stages and uses a registered carry.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub port. When sub=1,
// B is inverted and the carry starts at 1, so the block computes A - B.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);

    // The counter must be able to hold WIDTH, which it reaches after the last bit.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Half adder. The result is {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Full adder built from two half-adder stages. The result is {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic [1:0] h1;
        logic [1:0] h2;
        h1 = half_add(x, y);
        h2 = half_add(h1[0], ci);
        return {h1[1] | h2[1], h2[0]};
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             accept_s;
    logic             last_s;
    logic             sub_s;
    logic [1:0]       fa_s;
    logic [WIDTH-1:0] s_nxt_s;

    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] s_sr_r;
    logic [CW-1:0]    cnt_r;
    logic             c_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             busy_r;
    logic             done_r;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_s = sub;
`else
    assign sub_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic, plus the accept and last-bit strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = ST_DONE;
                    last_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bit-slice arithmetic. The new sum bit enters the result shift register at the MSB.
    always_comb begin
        fa_s             = full_add(a_sr_r[0], b_sr_r[0], c_r);
        s_nxt_s          = s_sr_r >> 1;
        s_nxt_s[WIDTH-1] = fa_s[0];
    end

    // Datapath: operand capture, serial shifting, result latching and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_r  <= '0;
            b_sr_r  <= '0;
            s_sr_r  <= '0;
            cnt_r   <= '0;
            c_r     <= 1'b0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                a_sr_r <= A;
                b_sr_r <= sub_s ? ~B : B;
                s_sr_r <= '0;
                cnt_r  <= '0;
                c_r    <= sub_s;
            end else if (state_r == ST_RUN) begin
                a_sr_r <= a_sr_r >> 1;
                b_sr_r <= b_sr_r >> 1;
                s_sr_r <= s_nxt_s;
                cnt_r  <= cnt_r + CW'(1);
                c_r    <= fa_s[1];
            end
            if (last_s) begin
                sum_r   <= s_nxt_s;
                carry_r <= fa_s[1];
            end
            busy_r <= (state_nxt_s == ST_RUN);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign Sum   = sum_r;
    assign Carry = carry_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl with WIDTH=8. The bench uses
// directed table vectors, hand-written corner sequences and random operations
// checked against an arithmetic reference model.
module tb_serial_adder_ctrl;

    localparam int W = 8;
`ifdef SERIAL_ADDER_SUB_EN
    localparam bit SUB_ON = 1'b1;
`else
    localparam bit SUB_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         sub_v;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Carry;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_prev_sum;
    logic         exp_prev_carry;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    vec_t vecs[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_v),
`endif
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Carry (Carry)
    );

    always #5 clk = ~clk;

    // Reference: {Carry,Sum} = A + B, or {A>=B, A-B mod 2^W} when subtracting.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] d;
        if (s) begin
            d = a - b;
            return {a >= b, d};
        end else begin
            return {1'b0, a} + {1'b0, b};
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts one operation and waits for done. The task scrambles A and B
    // after capture and checks that busy, Sum and Carry behave during RUN.
    // It also spends one extra cycle so that the block is back in IDLE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int lat, output logic [W-1:0] rs, output logic rc);
        logic hold_ok;
        A = a; B = b; sub_v = s; start = 1'b1;
        tick();
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); sub_v = ~s;
        hold_ok = busy;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done) begin
                lat = k;
                if (busy) hold_ok = 1'b0;
                break;
            end else if (!busy || Sum !== exp_prev_sum || Carry !== exp_prev_carry) begin
                hold_ok = 1'b0;
            end
        end
        rs = Sum;
        rc = Carry;
        check("run_hold", 32'(hold_ok), 32'd1);
        tick();
    endtask

    initial begin
        int           lat;
        logic [W-1:0] rs;
        logic         rc;
        logic [W:0]   m;
        int           t1;
        int           tr;
        int           t2;
        int           ndone;
        logic         ok;

        rst = 1'b1; start = 1'b0; A = '0; B = '0; sub_v = 1'b0;
        exp_prev_sum = '0; exp_prev_carry = 1'b0;

        // Directed vectors with hand-computed results
        vecs.push_back('{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
        if (SUB_ON) begin
            vecs.push_back('{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1});
            vecs.push_back('{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0});
            vecs.push_back('{8'h80, 8'h80, 1'b1, 8'h00, 1'b1});
            vecs.push_back('{8'h00, 8'hFF, 1'b1, 8'h01, 1'b0});
        end

        // Reset, then stay idle for five cycles
        tick(); tick();
        rst = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0 || Sum !== 8'h00 || Carry !== 1'b0) ok = 1'b0;
        end
        check("reset_idle", 32'(ok), 32'd1);

        // Table-driven vectors
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, lat, rs, rc);
            check("vec_latency", 32'(lat), 32'd8);
            check("vec_sum", 32'(rs), 32'(vecs[i].es));
            check("vec_carry", 32'(rc), 32'(vecs[i].ec));
            exp_prev_sum = vecs[i].es; exp_prev_carry = vecs[i].ec;
        end

        // Back-to-back operations with start held high through DONE
        A = 8'hFF; B = 8'h01; sub_v = 1'b0; start = 1'b1;
        tick();
        t1 = -1; tr = -1; t2 = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (done && t1 < 0) begin
                t1 = k;
                check("b2b_first_sum", 32'(Sum), 32'h00);
                check("b2b_first_carry", 32'(Carry), 32'd1);
                A = 8'h00; B = 8'h00;
            end else if (busy && t1 >= 0 && tr < 0) begin
                tr = k;
                start = 1'b0;
            end else if (done && tr >= 0) begin
                t2 = k;
                break;
            end
        end
        start = 1'b0;
        check("b2b_first_done", 32'(t1), 32'd8);
        check("b2b_restart", 32'(tr), 32'd10);
        check("b2b_second_done", 32'(t2), 32'd18);
        check("b2b_second_sum", 32'(Sum), 32'h00);
        check("b2b_second_carry", 32'(Carry), 32'd0);
        tick();
        exp_prev_sum = 8'h00; exp_prev_carry = 1'b0;

        // A start pulse during RUN is ignored and does not queue
        A = 8'h3C; B = 8'hE5; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 3) begin
                A = 8'h11; B = 8'h11; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) ndone++;
        end
        m = model(8'h3C, 8'hE5, 1'b0);
        check("ign_done_count", 32'(ndone), 32'd1);
        check("ign_sum", 32'(Sum), 32'(m[W-1:0]));
        check("ign_carry", 32'(Carry), 32'(m[W]));
        check("ign_idle", 32'(busy), 32'd0);

        // Reset during RUN cycle 4 aborts the operation
        A = 8'h77; B = 8'h66; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(Sum), 32'h00);
        check("abort_carry", 32'(Carry), 32'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done || busy) ndone++;
        end
        check("abort_quiet", 32'(ndone), 32'd0);
        exp_prev_sum = 8'h00; exp_prev_carry = 1'b0;
        do_op(8'hA5, 8'h5A, 1'b0, lat, rs, rc);
        check("post_abort_lat", 32'(lat), 32'd8);
        check("post_abort_sum", 32'(rs), 32'hFF);
        check("post_abort_carry", 32'(rc), 32'd0);
        exp_prev_sum = 8'hFF; exp_prev_carry = 1'b0;

        // Reset has priority over start in the same cycle
        rst = 1'b1; start = 1'b1; A = 8'h01; B = 8'h01;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_over_start_busy", 32'(busy), 32'd0);
        tick();
        check("rst_over_start_idle", 32'(busy), 32'd0);
        exp_prev_sum = 8'h00; exp_prev_carry = 1'b0;

        // Random operations checked against the model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rsub;
            ra = W'($urandom);
            rb = W'($urandom);
            rsub = SUB_ON ? 1'($urandom) : 1'b0;
            m = model(ra, rb, rsub);
            do_op(ra, rb, rsub, lat, rs, rc);
            check("rand_latency", 32'(lat), 32'd8);
            check("rand_sum", 32'(rs), 32'(m[W-1:0]));
            check("rand_carry", 32'(rc), 32'(m[W]));
            exp_prev_sum = m[W-1:0]; exp_prev_carry = m[W];
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
